partial_signature_combiner: RTL and testbench

Threshold combiner for partial signatures produced by the shard-keyed signing cores. It opens a session for one message hash and signing type, and collects shares over a valid/ready handshake. Duplicate, out-of-range or mismatched shares are discarded. Once THRESHOLD distinct shares are collected, the combiner emits the full 256-bit signature. It sits downstream of the partial-signature path, on the enclave's aggregation side.

---
 rtl/partial_signature_combiner.sv | 204 ++++++++++++++++++++
 tb/tb_partial_signature_combiner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/partial_signature_combiner.sv
// ---------------------------------------------------------------------------
// partial_signature_combiner
//   Threshold combiner for partial signatures. A session is opened for one
//   message hash and signing type. Shares arrive over a valid/ready handshake
//   and are summed modulo 2^256 until THRESHOLD distinct shards have
//   contributed. The sum is then published on signature_out with a done pulse.
//   Duplicate, out-of-range or type-mismatched shares are discarded. A session
//   that sees no accepted share for TIMEOUT_CYCLES cycles is aborted.
//
//   Optional feature macro: COMBINER_HASH_BINDING_EN
//     Adds the share_hash input. A share whose hash differs from the latched
//     message hash is discarded like any other bad share.
// ---------------------------------------------------------------------------
module partial_signature_combiner #(
   parameter int NUM_SHARDS     = 3,
   parameter int THRESHOLD      = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   signing_type,
   input  logic [127:0] message_hash,
   input  logic         share_valid,
   output logic         share_ready,
   input  logic [3:0]   share_index,
   input  logic [1:0]   share_type,
   input  logic [255:0] share_sig,
`ifdef COMBINER_HASH_BINDING_EN
   input  logic [127:0] share_hash,
`endif
   output logic         share_rejected,
   output logic         busy,
   output logic [255:0] signature_out,
   output logic         done,
   output logic         error,
   output logic [1:0]   error_code
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_COMBINE = 2'd2;

   localparam int CNT_W = $clog2(NUM_SHARDS + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [4:0]       NUM_SHARDS_C = 5'(NUM_SHARDS);
   localparam logic [CNT_W-1:0] THRESHOLD_C  = CNT_W'(THRESHOLD);
   localparam logic [TMO_W-1:0] TMO_LAST_C   = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] TYPE_ILLEGAL = 2'b11;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_TYPE     = 2'b10;

   logic [1:0]            state_q,   state_d;
   logic [255:0]          acc_q,     acc_d;
   logic [NUM_SHARDS-1:0] seen_q,    seen_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [TMO_W-1:0]      tmo_q,     tmo_d;
   logic [1:0]            type_q,    type_d;
   logic [255:0]          sig_q,     sig_d;
   logic                  done_q,    done_d;
   logic                  err_q,     err_d;
   logic [1:0]            code_q,    code_d;
   logic                  rej_q,     rej_d;
`ifdef COMBINER_HASH_BINDING_EN
   logic [127:0]          hash_q,    hash_d;
`endif

   // Seen bitmap widened to the full index range so any 4-bit index is legal.
   logic [15:0] seen_ext;
   logic [15:0] seen_set;
   logic        handshake;
   logic        share_ok;

   // Classify the share on the bus: in range, not yet seen, matching session.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
      seen_ext                 = '0;
      seen_ext[NUM_SHARDS-1:0] = seen_q;
      seen_set                 = seen_ext | (16'd1 << share_index);
      handshake                = share_valid && share_ready;
      share_ok                 = ({1'b0, share_index} < NUM_SHARDS_C)
                                 && !seen_ext[share_index]
                                 && (share_type == type_q);
`ifdef COMBINER_HASH_BINDING_EN
      share_ok                 = share_ok && (share_hash == hash_q);
`endif
   end

   // Next-state logic for the session FSM and its datapath.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      seen_d  = seen_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      type_d  = type_q;
      sig_d   = sig_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      rej_d   = 1'b0;
`ifdef COMBINER_HASH_BINDING_EN
      hash_d  = hash_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (signing_type == TYPE_ILLEGAL) begin
                  err_d  = 1'b1;
                  code_d = ERR_TYPE;
               end else begin
                  type_d  = signing_type;
`ifdef COMBINER_HASH_BINDING_EN
                  hash_d  = message_hash;
`endif
                  acc_d   = '0;
                  seen_d  = '0;
                  cnt_d   = '0;
                  tmo_d   = '0;
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (handshake && share_ok) begin
               // An accept beats a simultaneous timeout expiry.
               acc_d  = acc_q + share_sig;
               seen_d = seen_set[NUM_SHARDS-1:0];
               cnt_d  = cnt_q + 1'b1;
               tmo_d  = '0;
               if (cnt_d == THRESHOLD_C) begin
                  state_d = ST_COMBINE;
               end
            end else begin
               rej_d = handshake;
               if (tmo_q == TMO_LAST_C) begin
                  err_d   = 1'b1;
                  code_d  = ERR_TIMEOUT;
                  acc_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         ST_COMBINE: begin
            sig_d   = acc_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any session immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the accumulator is plain flops, so it is reset with everything else rather than left undefined.
         state_q <= ST_IDLE;
         acc_q   <= '0;
         seen_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         type_q  <= '0;
         sig_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
         rej_q   <= 1'b0;
`ifdef COMBINER_HASH_BINDING_EN
         hash_q  <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state_q <= state_d;
         acc_q   <= acc_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         type_q  <= type_d;
         sig_q   <= sig_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         rej_q   <= rej_d;
`ifdef COMBINER_HASH_BINDING_EN
         hash_q  <= hash_d;
`endif
      end
   end

   assign share_ready    = (state_q == ST_COLLECT);
   assign busy           = (state_q != ST_IDLE);
   assign share_rejected = rej_q;
   assign signature_out  = sig_q;
   assign done           = done_q;
   assign error          = err_q;
   assign error_code     = code_q;

endmodule

// File: tb/tb_partial_signature_combiner.sv
// ---------------------------------------------------------------------------
// tb_partial_signature_combiner
//   Directed and randomized sessions against a cycle model built from the
//   combiner's session rules (distinct-shard sum, reject causes, idle timeout).
// ---------------------------------------------------------------------------
module tb_partial_signature_combiner;

   localparam int NSH = 3;
   localparam int TH  = 2;
   localparam int TMO = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   signing_type;
   logic [127:0] message_hash;
   logic         share_valid;
   logic         share_ready;
   logic [3:0]   share_index;
   logic [1:0]   share_type;
   logic [255:0] share_sig;
`ifdef COMBINER_HASH_BINDING_EN
   logic [127:0] share_hash;
`endif
   logic         share_rejected;
   logic         busy;
   logic [255:0] signature_out;
   logic         done;
   logic         error;
   logic [1:0]   error_code;

   partial_signature_combiner #(
      .NUM_SHARDS(NSH), .THRESHOLD(TH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .signing_type(signing_type),
      .message_hash(message_hash), .share_valid(share_valid),
      .share_ready(share_ready), .share_index(share_index),
      .share_type(share_type), .share_sig(share_sig),
`ifdef COMBINER_HASH_BINDING_EN
      .share_hash(share_hash),
`endif
      .share_rejected(share_rejected), .busy(busy),
      .signature_out(signature_out), .done(done), .error(error),
      .error_code(error_code)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: session phase 0 idle, 1 collecting, 2 combining.
   int           m_phase = 0;
   logic [1:0]   m_type  = '0;
   logic [127:0] m_hash  = '0;
   logic [255:0] m_sum   = '0;
   logic [255:0] m_sig   = '0;
   logic [1:0]   m_code  = '0;
   bit           m_seen [16];
   int           m_cnt   = 0;
   int           m_idle  = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock edge: drive inputs, advance, update the model, compare all outputs.
   task automatic edge_step(input logic st, input logic [1:0] stype, input logic [127:0] mhash,
                            input logic v, input logic [3:0] idx, input logic [1:0] ty,
                            input logic [255:0] sig, input logic [127:0] shash);
      logic exp_rej, exp_done, exp_err, bad;
      start        = st;
      signing_type = stype;
      message_hash = mhash;
      share_valid  = v;
      share_index  = idx;
      share_type   = ty;
      share_sig    = sig;
`ifdef COMBINER_HASH_BINDING_EN
      share_hash   = shash;
`endif
      @(posedge clk);
      #1;
      start       = 1'b0;
      share_valid = 1'b0;
      exp_rej = 0; exp_done = 0; exp_err = 0;
      case (m_phase)
         2: begin
            m_sig    = m_sum;
            exp_done = 1;
            m_phase  = 0;
         end
         1: begin
            bad = 1;
            if (v) begin
               bad = (int'(idx) >= NSH) || m_seen[idx] || (ty != m_type);
`ifdef COMBINER_HASH_BINDING_EN
               bad = bad || (shash != m_hash);
`endif
               exp_rej = bad;
            end
            if (!bad) begin
               m_sum       = m_sum + sig;
               m_seen[idx] = 1;
               m_cnt++;
               m_idle = 0;
               if (m_cnt == TH) m_phase = 2;
            end else begin
               m_idle++;
               if (m_idle == TMO) begin
                  exp_err = 1;
                  m_code  = 2'b01;
                  m_phase = 0;
               end
            end
         end
         default: begin
            if (st) begin
               if (stype == 2'b11) begin
                  exp_err = 1;
                  m_code  = 2'b10;
               end else begin
                  m_phase = 1;
                  m_type  = stype;
                  m_hash  = mhash;
                  m_sum   = '0;
                  m_cnt   = 0;
                  m_idle  = 0;
                  foreach (m_seen[i]) m_seen[i] = 0;
               end
            end
         end
      endcase
      check("share_ready", 256'(share_ready), 256'(m_phase == 1));
      check("busy", 256'(busy), 256'(m_phase != 0));
      check("share_rejected", 256'(share_rejected), 256'(exp_rej));
      check("done", 256'(done), 256'(exp_done));
      check("error", 256'(error), 256'(exp_err));
      check("error_code", 256'(error_code), 256'(m_code));
      check("signature_out", signature_out, m_sig);
   endtask

   task automatic idle();
      edge_step(0, 2'b00, '0, 0, 4'd0, 2'b00, '0, '0);
   endtask

   task automatic open_session(input logic [1:0] t, input logic [127:0] h);
      edge_step(1, t, h, 0, 4'd0, 2'b00, '0, '0);
   endtask

   task automatic send(input logic [3:0] idx, input logic [1:0] ty, input logic [255:0] sig);
      edge_step(0, 2'b00, '0, 1, idx, ty, sig, m_hash);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #2;
      m_phase = 0; m_sig = '0; m_code = '0;
      check("rst_share_ready", 256'(share_ready), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_share_rejected", 256'(share_rejected), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_error", 256'(error), 256'(0));
      check("rst_error_code", 256'(error_code), 256'(0));
      check("rst_signature_out", signature_out, 256'(0));
      reset = 1'b0;
   endtask

   initial begin
      logic [255:0] a, b;
      logic [127:0] h;
      reset = 1'b1; start = 0; signing_type = 0; message_hash = 0;
      share_valid = 0; share_index = 0; share_type = 0; share_sig = 0;
`ifdef COMBINER_HASH_BINDING_EN
      share_hash = 0;
`endif
      #12;
      apply_reset();

      // Basic combine: 5 + 7.
      open_session(2'b01, 128'h1234);
      send(4'd0, 2'b01, 256'd5);
      send(4'd2, 2'b01, 256'd7);
      idle();
      check("sum_5_7", signature_out, 256'd12);
      idle();

      // Wrap-around: (2^256-1) + 3 = 2.
      open_session(2'b01, 128'h55);
      send(4'd1, 2'b01, {256{1'b1}});
      send(4'd0, 2'b01, 256'd3);
      idle();
      check("sum_wrap", signature_out, 256'd2);
      idle();

      // Duplicate, out-of-range and wrong-type shares are discarded.
      a = rand256(); b = rand256();
      open_session(2'b01, 128'h77);
      send(4'd1, 2'b01, a);
      send(4'd1, 2'b01, a);
      send(4'd4, 2'b01, a);
      send(4'd0, 2'b10, b);
      send(4'd0, 2'b01, b);
      idle();
      check("sum_once", signature_out, a + b);
      idle();

      // Timeout: one share then silence; prior signature retained.
      open_session(2'b00, 128'h99);
      send(4'd2, 2'b00, rand256());
      repeat (TMO) idle();
      check("timeout_code", 256'(error_code), 256'(2'b01));
      check("timeout_sig_kept", signature_out, a + b);
      idle();

      // Illegal signing type is refused.
      open_session(2'b11, 128'h0);
      check("illegal_busy", 256'(busy), 256'(0));
      idle();

      // Reset mid-collect discards the session.
      open_session(2'b10, 128'hAB);
      send(4'd0, 2'b10, rand256());
      apply_reset();
      a = rand256(); b = rand256();
      open_session(2'b10, 128'hAB);
      send(4'd0, 2'b10, a);
      send(4'd1, 2'b10, b);
      idle();
      check("after_reset_sum", signature_out, a + b);
      idle();

`ifdef COMBINER_HASH_BINDING_EN
      // Hash binding: bit-0 mismatch rejected, matching shares combine.
      h = 128'hDEAD_BEEF;
      a = rand256(); b = rand256();
      open_session(2'b01, h);
      edge_step(0, 2'b00, '0, 1, 4'd0, 2'b01, a, h ^ 128'd1);
      send(4'd0, 2'b01, a);
      send(4'd2, 2'b01, b);
      idle();
      check("hash_sum", signature_out, a + b);
      idle();
`endif

      // Randomized sessions, including gaps, bad shares and timeouts.
      for (int s = 0; s < 30; s++) begin
         h = {$urandom, $urandom, $urandom, $urandom};
         open_session(2'($urandom_range(0, 3)), h);
         for (int c = 0; c < 40 && m_phase != 0; c++) begin
            if (m_phase == 1 && $urandom_range(0, 3) != 0)
               send(4'($urandom_range(0, 4)),
                    ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : m_type,
                    rand256());
            else
               idle();
         end
         check("rand_session_closed", 256'(m_phase), 256'(0));
         idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
